// File: rtl/reset_sequencer.sv
// CPU reset sequencer: power-on hold, debounced push-button, watchdog and software
// reset requests, driving registered RESET/HALT/RUN outputs and the last reset cause.
module reset_sequencer #(
    parameter int unsigned POR_CYCLES      = 10000,
    parameter int unsigned PULSE_CYCLES    = 124,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES   = 16
) (
    input  logic       CPUCLK_IN,
    input  logic       RESET_IN,
    input  logic       BTN_N_IN,
    input  logic       WDT_REQ_IN,
    input  logic       SW_REQ_IN,
    output logic       RESET,
    output logic       HALT,
    output logic       RUN,
    output logic [1:0] CAUSE
);

    // POR is timed from the first edge that samples RESET_IN low, so its counter
    // runs one step further than the other timed states, which start at state entry.
    localparam logic [15:0] POR_LAST    = 16'(POR_CYCLES);
    localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DEB_LAST    = 16'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_BTN = 2'd1;
    localparam logic [1:0] CAUSE_WDT = 2'd2;
    localparam logic [1:0] CAUSE_SW  = 2'd3;

    typedef enum logic [2:0] {
        ST_POR,
        ST_ASSERT,
        ST_HOLD,
        ST_SETTLE,
        ST_RUN
    } state_e;

    logic        sync1_q, sync2_q;
    logic        deb_q, deb_d;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        reset_q, reset_d;
    logic        run_q, run_d;
    logic [1:0]  cause_q, cause_d;
    logic        btn_req;
    logic        any_req;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = 16'd0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    // The press is acted on at the same edge the debounced level falls.
    assign btn_req = deb_q & ~deb_d;
    assign any_req = btn_req | WDT_REQ_IN | SW_REQ_IN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_POR: begin
                if (cnt_q == POR_LAST) begin
                    state_d = deb_q ? ST_SETTLE : ST_HOLD;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = deb_q ? ST_SETTLE : ST_HOLD;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_HOLD: begin
                cnt_d = 16'd0;
                if (deb_q) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RUN: cnt_d = 16'd0;
            default: begin
                state_d = ST_POR;
                cnt_d   = 16'd0;
            end
        endcase

        if ((state_q == ST_SETTLE || state_q == ST_RUN) && any_req) begin
            state_d = ST_ASSERT;
            cnt_d   = 16'd0;
            if (btn_req)         cause_d = CAUSE_BTN;
            else if (WDT_REQ_IN) cause_d = CAUSE_WDT;
            else                 cause_d = CAUSE_SW;
        end

        // Outputs are decoded from the next state so they change on the transition edge.
        reset_d = (state_d == ST_POR) || (state_d == ST_ASSERT) || (state_d == ST_HOLD);
        run_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_cnt_q <= 16'd0;
            state_q   <= ST_POR;
            cnt_q     <= 16'd0;
            reset_q   <= 1'b1;
            run_q     <= 1'b0;
            cause_q   <= CAUSE_POR;
        end else begin
            sync1_q   <= BTN_N_IN;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reset_q   <= reset_d;
            run_q     <= run_d;
            cause_q   <= cause_d;
        end
    end

    assign RESET = reset_q;
    assign HALT  = reset_q;
    assign RUN   = run_q;
    assign CAUSE = cause_q;

endmodule
